// File: rtl/baseerat_arb2_skid.sv
// baseerat_arb2_skid: two-input round-robin arbiter feeding a registered
// main + skid output buffer. out_sel=1 marks a beat taken from in0.
// Optional packet lock (in/out *_last ports) when BASEERAT_ARB2_PKT_LOCK_EN
// is defined; the default build arbitrates per beat.
module baseerat_arb2_skid #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned RR_INIT    = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in0_valid,
   input  logic [DATA_WIDTH-1:0] in0_data,
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
   input  logic                  in0_last,
`endif
   output logic                  in0_ready,
   input  logic                  in1_valid,
   input  logic [DATA_WIDTH-1:0] in1_data,
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
   input  logic                  in1_last,
`endif
   output logic                  in1_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sel,
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
   output logic                  out_last,
`endif
   input  logic                  out_ready
);

   localparam logic PRIO_INIT = (RR_INIT != 0);

   logic                  prio;
   logic                  skid_vld;
   logic                  skid_sel;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  can_acc;
   logic                  gnt0;
   logic                  gnt1;
   logic                  acc;
   logic                  drain;
   logic                  beat_sel;
   logic [DATA_WIDTH-1:0] beat_data;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
   logic                  lock_act;
   logic                  lock_src;
   logic                  skid_last;
   logic                  beat_last;
`endif

   // Grant, ready and winning-beat selection; readies depend only on registered state and valids.
   always_comb begin
      can_acc = resetn & ~skid_vld;
      gnt0    = in0_valid & (~in1_valid | ~prio);
      gnt1    = in1_valid & (~in0_valid |  prio);
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      if (lock_act) begin
         gnt0 = in0_valid & ~lock_src;
         gnt1 = in1_valid &  lock_src;
      end
      beat_last = gnt0 ? in0_last : in1_last;
`endif
      in0_ready = can_acc & gnt0;
      in1_ready = can_acc & gnt1;
      acc       = in0_ready | in1_ready;
      drain     = out_valid & out_ready;
      beat_sel  = gnt0;
      beat_data = gnt0 ? in0_data : in1_data;
   end

   // Round-robin pointer: after accepting from inX the other input is preferred (prio=1 favours in1).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prio <= PRIO_INIT;
      end else if (acc) begin
         prio <= beat_sel;
      end
   end

`ifdef BASEERAT_ARB2_PKT_LOCK_EN
   // Packet lock: hold the grant on the source of a non-final beat until its last beat is taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_act <= 1'b0;
         lock_src <= 1'b0;
      end else if (acc) begin
         lock_act <= ~beat_last;
         lock_src <= ~beat_sel;
      end
   end
`endif

   // Output buffer: main register refills from skid first, else from the accepted beat.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 1'b0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         skid_sel  <= 1'b0;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
         out_last  <= 1'b0;
         skid_last <= 1'b0;
`endif
      end else if (drain && skid_vld) begin
         out_data <= skid_data;
         out_sel  <= skid_sel;
         skid_vld <= 1'b0;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
         out_last <= skid_last;
`endif
      end else if (acc) begin
         if (!out_valid || drain) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_sel   <= beat_sel;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
            out_last  <= beat_last;
`endif
         end else begin
            skid_vld  <= 1'b1;
            skid_data <= beat_data;
            skid_sel  <= beat_sel;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
            skid_last <= beat_last;
`endif
         end
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_baseerat_arb2_skid.sv
// Directed, table-driven bench for baseerat_arb2_skid (RR_INIT=0, 16-bit data).
module tb_baseerat_arb2_skid;

   typedef struct {
      logic        v0;
      logic [15:0] d0;
      logic        l0;
      logic        v1;
      logic [15:0] d1;
      logic        l1;
      logic        ordy;
      logic        er0;
      logic        er1;
      logic        eov;
      logic [15:0] eod;
      logic        esel;
      logic        elast;
   } vec_t;

   logic        clk;
   logic        resetn;
   logic        in0_valid;
   logic [15:0] in0_data;
   logic        in0_ready;
   logic        in1_valid;
   logic [15:0] in1_data;
   logic        in1_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_sel;
   logic        out_ready;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
   logic        in0_last;
   logic        in1_last;
   logic        out_last;
`endif

   int checks = 0;
   int errors = 0;

   baseerat_arb2_skid #(.DATA_WIDTH(16), .RR_INIT(0)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      .in0_last  (in0_last),
`endif
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      .in1_last  (in1_last),
`endif
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      .out_last  (out_last),
`endif
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v0, input logic [15:0] d0,
                               input logic v1, input logic [15:0] d1, input logic ordy,
                               input logic er0, input logic er1,
                               input logic eov, input logic [15:0] eod, input logic esel);
      vec_t v;
      v.v0 = v0;  v.d0 = d0;  v.l0 = 1'b1;
      v.v1 = v1;  v.d1 = d1;  v.l1 = 1'b1;
      v.ordy = ordy;
      v.er0 = er0; v.er1 = er1;
      v.eov = eov; v.eod = eod; v.esel = esel; v.elast = 1'b1;
      return v;
   endfunction

   // Drive one vector, check readies before the edge and registered outputs after it.
   task automatic drive_check(input vec_t v, input string tag);
      in0_valid = v.v0;
      in0_data  = v.d0;
      in1_valid = v.v1;
      in1_data  = v.d1;
      out_ready = v.ordy;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      in0_last  = v.l0;
      in1_last  = v.l1;
`endif
      #1;
      chk({tag, ".in0_ready"}, 32'(in0_ready), 32'(v.er0));
      chk({tag, ".in1_ready"}, 32'(in1_ready), 32'(v.er1));
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.eov));
      if (v.eov) begin
         chk({tag, ".out_data"}, 32'(out_data), 32'(v.eod));
         chk({tag, ".out_sel"}, 32'(out_sel), 32'(v.esel));
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
         chk({tag, ".out_last"}, 32'(out_last), 32'(v.elast));
`endif
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      drive_check(v, tag);
   endtask

   // Park main+skid with two in0 beats (leaves prio favouring in1), then reset asynchronously.
   task automatic fill_and_reset(input string tag);
      step(mk(1, 16'h0055, 0, 16'h0, 0,  1, 0,  1, 16'h0055, 1), {tag, ".fill0"});
      step(mk(1, 16'h0056, 0, 16'h0, 0,  1, 0,  1, 16'h0055, 1), {tag, ".fill1"});
      @(negedge clk);
      in0_valid = 1'b1;
      in0_data  = 16'h0057;
      #1;
      chk({tag, ".full_in0_ready"}, 32'(in0_ready), 32'd0);
      #2;
      resetn = 1'b0;
      #1;
      chk({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".rst_out_data"}, 32'(out_data), 32'd0);
      chk({tag, ".rst_out_sel"}, 32'(out_sel), 32'd0);
      chk({tag, ".rst_in0_ready"}, 32'(in0_ready), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   vec_t vecs[21];

   initial begin
      vec_t v;
      resetn    = 1'b0;
      in0_valid = 1'b1;
      in0_data  = 16'h1234;
      in1_valid = 1'b1;
      in1_data  = 16'h4321;
      out_ready = 1'b1;
`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      in0_last  = 1'b1;
      in1_last  = 1'b1;
`endif

      // Alternation from reset, in1-only streaming, then idle.
      vecs[0]  = mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0,  1, 16'hAAAA, 1);
      vecs[1]  = mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 1,  1, 16'h5555, 0);
      vecs[2]  = mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0,  1, 16'hAAAA, 1);
      vecs[3]  = mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 1,  1, 16'h5555, 0);
      vecs[4]  = mk(0, 16'h0,    1, 16'h0001, 1,  0, 1,  1, 16'h0001, 0);
      vecs[5]  = mk(0, 16'h0,    1, 16'h0002, 1,  0, 1,  1, 16'h0002, 0);
      vecs[6]  = mk(0, 16'h0,    1, 16'h0003, 1,  0, 1,  1, 16'h0003, 0);
      vecs[7]  = mk(0, 16'h0,    1, 16'h0004, 1,  0, 1,  1, 16'h0004, 0);
      vecs[8]  = mk(0, 16'h0,    0, 16'h0,    1,  0, 0,  0, 16'h0,    0);
      // Backpressure on in0: main, skid, then full; drain from skid blocks acceptance that cycle.
      vecs[9]  = mk(1, 16'd10,   0, 16'h0,    0,  1, 0,  1, 16'd10,   1);
      vecs[10] = mk(1, 16'd11,   0, 16'h0,    0,  1, 0,  1, 16'd10,   1);
      vecs[11] = mk(1, 16'd12,   0, 16'h0,    0,  0, 0,  1, 16'd10,   1);
      vecs[12] = mk(1, 16'd12,   0, 16'h0,    1,  0, 0,  1, 16'd11,   1);
      vecs[13] = mk(1, 16'd12,   0, 16'h0,    1,  1, 0,  1, 16'd12,   1);
      vecs[14] = mk(0, 16'h0,    0, 16'h0,    1,  0, 0,  0, 16'h0,    0);
      // Both inputs under backpressure; order 31,21,32,22 must be kept.
      vecs[15] = mk(1, 16'h0021, 1, 16'h0031, 0,  0, 1,  1, 16'h0031, 0);
      vecs[16] = mk(1, 16'h0021, 1, 16'h0032, 0,  1, 0,  1, 16'h0031, 0);
      vecs[17] = mk(1, 16'h0022, 1, 16'h0032, 1,  0, 0,  1, 16'h0021, 1);
      vecs[18] = mk(1, 16'h0022, 1, 16'h0032, 1,  0, 1,  1, 16'h0032, 0);
      vecs[19] = mk(1, 16'h0022, 1, 16'h0033, 1,  1, 0,  1, 16'h0022, 1);
      vecs[20] = mk(0, 16'h0,    0, 16'h0,    1,  0, 0,  0, 16'h0,    0);

      #3;
      chk("reset.in0_ready", 32'(in0_ready), 32'd0);
      chk("reset.in1_ready", 32'(in1_ready), 32'd0);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_data", 32'(out_data), 32'd0);
      chk("reset.out_sel", 32'(out_sel), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      resetn    = 1'b1;

      for (int i = 0; i < 21; i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset mid-operation, then a lone in1 beat on the first edge after release.
      fill_and_reset("rst1");
      drive_check(mk(0, 16'h0, 1, 16'h00FF, 1,  0, 1,  1, 16'h00FF, 0), "rst1.first");
      step(mk(0, 16'h0, 0, 16'h0, 1,  0, 0,  0, 16'h0, 0), "rst1.idle");

      // Reset mid-operation with prio favouring in1: after release in0 must win again.
      fill_and_reset("rst2");
      drive_check(mk(1, 16'h0A0A, 1, 16'h00FF, 1,  1, 0,  1, 16'h0A0A, 1), "rst2.first");
      step(mk(0, 16'h0, 0, 16'h0, 1,  0, 0,  0, 16'h0, 0), "rst2.idle");

`ifdef BASEERAT_ARB2_PKT_LOCK_EN
      @(negedge clk);
      resetn    = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      v = mk(1, 16'h00C1, 1, 16'h00D1, 1,  1, 0,  1, 16'h00C1, 1);
      v.l0 = 1'b0; v.elast = 1'b0;
      step(v, "lock.beat1");
      v = mk(0, 16'h0, 1, 16'h00D1, 1,  0, 0,  0, 16'h0, 0);
      step(v, "lock.idle_locked");
      v = mk(1, 16'h00C2, 1, 16'h00D1, 1,  1, 0,  1, 16'h00C2, 1);
      v.l0 = 1'b0; v.elast = 1'b0;
      step(v, "lock.beat2");
      v = mk(1, 16'h00C3, 1, 16'h00D1, 1,  1, 0,  1, 16'h00C3, 1);
      step(v, "lock.beat3");
      v = mk(1, 16'h00C4, 1, 16'h00D1, 1,  0, 1,  1, 16'h00D1, 0);
      step(v, "lock.in1_next");
      v = mk(0, 16'h0, 0, 16'h0, 1,  0, 0,  0, 16'h0, 0);
      step(v, "lock.idle");
`else
      v = mk(0, 16'h0, 0, 16'h0, 1,  0, 0,  0, 16'h0, 0);
      step(v, "tail.idle");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/baseerat_arb2_skid.md
Name: baseerat_arb2_skid

Overview:
Two-input, flow-controlled round-robin arbiter with a registered two-entry skid output buffer.
- Sits directly upstream of the team's general-purpose 2:1 data mux. It decides which of two valid/ready sources wins each beat, and emits the winning data with a source tag.
- Source tag polarity matches the mux convention: input 0 is the sel=1 leg, so out_sel=1 means the beat came from in0.
- Sustains one beat per cycle with a fully registered output path, including under downstream backpressure.

Parameters:
- DATA_WIDTH, 16, payload width in bits; legal values are 1..15 or multiples of 16.
- RR_INIT, 0, input given priority first after reset (0 or 1).

Ports:
- clk, input, 1, single clock; all state is on the rising edge.
- resetn, input, 1, asynchronous active-low reset; deassertion is synchronous to clk (synchronised externally).
- in0_valid, input, 1, source 0 has a beat.
- in0_data, input, DATA_WIDTH, source 0 payload.
- in0_ready, output, 1, source 0 beat accepted this cycle when in0_valid & in0_ready.
- in1_valid, input, 1, source 1 has a beat.
- in1_data, input, DATA_WIDTH, source 1 payload.
- in1_ready, output, 1, source 1 beat accepted this cycle when in1_valid & in1_ready.
- out_valid, output, 1, registered; output beat present.
- out_data, output, DATA_WIDTH, registered payload.
- out_sel, output, 1, registered; 1 means the beat came from in0, 0 means in1.
- out_ready, input, 1, downstream accepts when out_valid & out_ready.

Behaviour:
- **Reset (async, while resetn=0):** out_valid=0, out_data=0, out_sel=0, skid_vld=0, skid_data=0, prio=RR_INIT. No input ready is asserted while in reset.
- **Acceptance enable:** can_acc = ~skid_vld. This is a registered term, so there is no combinational path from out_ready to inX_ready.
- **Grant (combinational):**
  - gnt0 = in0_valid & (~in1_valid | prio==0).
  - gnt1 = in1_valid & (~in0_valid | prio==1).
  - At most one grant is active.
- **Ready outputs:** in0_ready = can_acc & gnt0; in1_ready = can_acc & gnt1. Ready is never asserted for an input that is not valid.
- **Priority update:** on an accepted beat from input X, prio <= ~X, so the loser of a tie wins next. With no acceptance, prio holds.
- **Output buffer (main register plus skid register):**
  - Drain condition: drain = out_valid & out_ready.
  - Accepted beat, main empty or draining, skid empty: main <= beat (out_valid=1, out_sel=gnt0).
  - Accepted beat, main full and not draining: skid <= beat, skid_vld <= 1.
  - Drain with skid_vld=1: main <= skid, skid_vld <= 0. No accept can occur in this cycle because can_acc=0.
  - Drain with skid empty and no accept: out_valid <= 0. out_data and out_sel hold their last values.
- **Latency:** one cycle from input acceptance to out_valid when main is empty or draining.
- **Throughput:** one beat per cycle while out_ready=1.
- **Ordering:** beats leave in acceptance order. Data is never dropped or duplicated.
- **Stability:** while out_valid=1 and out_ready=0, out_data and out_sel remain stable.
- **Capacity:** at most two beats are held internally (main plus skid). When both are full, both inX_ready are 0.
- **Reset mid-operation:** all buffered beats are discarded, prio returns to RR_INIT, and the block accepts the first valid beat on the first edge after reset release.
- **Input rules:** inX_data is sampled only on the accepting edge. Upstream must hold valid and data until accepted; if valid is dropped before acceptance, no beat is taken.

Optional Feature:
- Macro: BASEERAT_ARB2_PKT_LOCK_EN.
- **Defined:**
  - Adds input ports in0_last and in1_last (1 bit each) and output port out_last (1 bit, registered; it travels with the beat through main and skid, reset value 0).
  - After an input wins an accepted beat with last=0, the grant locks to that input. The other input gets no ready, even if it is valid and the locked input is idle.
  - The lock releases on the accepted beat with last=1, and prio then flips as in the normal rule.
  - Reset clears the lock.
- **Undefined:** arbitration is per beat, and none of the last ports exist.

Test Plan:
- Reset with RR_INIT=0, both valid, in0_data=16'hAAAA, in1_data=16'h5555, out_ready=1 -> outputs alternate AAAA/5555 every cycle, out_sel alternates 1,0,1,0, starting with AAAA one cycle after the first accept.
- Only in1 valid with data 1..4, out_ready=1 -> in1_ready=1 every cycle; out_data is 1,2,3,4 on consecutive cycles, out_sel=0, and 1-cycle latency.
- Backpressure: in0 streams 10,11,12 while out_ready=0 -> 10 lands in main and 11 in skid, then in0_ready=0 with 12 held. Raising out_ready yields 10,11,12 in order, with no loss and no duplicate.
- Assert resetn=0 asynchronously with two beats buffered -> out_valid=0 immediately and prio=RR_INIT. After release, a fresh in1 beat 16'h00FF appears next cycle with out_sel=0.
- Simultaneous drain from skid and new valid input -> that cycle's inX_ready=0. The next cycle accepts, and output order is preserved.
- With BASEERAT_ARB2_PKT_LOCK_EN defined: in0 sends a 3-beat packet (last on beat 3) while in1 is valid throughout -> in1_ready=0 until in0's last is accepted, then in1 is granted next with out_last=1 only on beat 3 of in0.
